// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, FSM state encodings and frame-length helper.
package uart_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam int UART_CLKS_PER_BIT_9600 = 192;
    localparam int UART_FRAME_CLKS_8N1    = 10 * UART_CLKS_PER_BIT_9600;
    localparam int UART_FRAME_CLKS_8N2    = 11 * UART_CLKS_PER_BIT_9600;

    function automatic int uart_frame_clks(input int clks_per_bit, input int stop_bits);
        return (9 + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 192
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    assign bit_done = cnt == LAST;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else        cnt <= (clear || bit_done) ? '0 : cnt + 1'b1;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 UART transmitter with a one-byte holding register on a valid/ready input.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_9600,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       ready,
    output logic       serial_out,
    output logic       busy
);

    logic [1:0] state;
    logic [7:0] hold;
    logic [7:0] shifter;
    logic       full;
    logic [2:0] idx;
    logic       bit_done;
    logic       accept;
    logic       last_stop;
    logic       load;

    // Every non-IDLE transition happens on bit_done, where the counter wraps by itself,
    // so holding it clear in IDLE is enough to restart it on every state entry.
    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state == IDLE),
        .bit_done (bit_done)
    );

    assign accept    = data_valid && ready;
    assign last_stop = idx == 3'(STOP_BITS - 1);
    assign load      = full && (state == IDLE || (state == STOP && bit_done && last_stop));
    assign busy      = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold       <= '0;
            shifter    <= '0;
            full       <= 1'b0;
            idx        <= '0;
            ready      <= 1'b1;
            serial_out <= 1'b1;
        end else begin
            serial_out <= state == START ? 1'b0 : state == DATA ? shifter[0] : 1'b1;
            // ready only rises the cycle after the holding register has emptied
            if (accept) begin
                hold  <= data_in;
                full  <= 1'b1;
                ready <= 1'b0;
            end else begin
                if (load) full <= 1'b0;
                if (!full) ready <= 1'b1;
            end
            if (load) shifter <= hold;
            else if (state == DATA && bit_done) shifter <= shifter >> 1;
            case (state)
                IDLE:  if (full) state <= START;
                START: if (bit_done) state <= DATA;
                DATA:  if (bit_done) begin
                    idx <= idx + 3'd1;
                    if (idx == 3'd7) state <= STOP;
                end
                default: if (bit_done) begin
                    if (last_stop) begin
                        idx   <= '0;
                        state <= full ? START : IDLE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
            endcase
        end
    end

endmodule
